// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the latency counter width.
package md_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including the
// divide-by-zero and signed-overflow results.
module md_arith
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [2*WIDTH-1:0]      prod_s;
   logic [2*WIDTH-1:0]      prod_u;
   logic                    div_zero;
   logic                    div_ovf;
   logic [WIDTH-1:0]        b_safe;
   logic signed [WIDTH-1:0] quo_s;
   logic signed [WIDTH-1:0] rem_s;
   logic [WIDTH-1:0]        quo_u;
   logic [WIDTH-1:0]        rem_u;

   // Products, quotients and remainders; the divisor is forced to 1 in the
   // special cases so the dividers never see /0 or MIN/-1.
   always_comb begin
      // Signed product via sign-extended unsigned multiply: low 2W bits match.
      prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      div_zero = (b == '0);
      div_ovf  = (op == MD_DIV) && (a == MIN_NEG) && (b == '1);
      b_safe   = (div_zero || div_ovf) ? ONE : b;
      quo_s    = $signed(a) / $signed(b_safe);
      rem_s    = $signed(a) % $signed(b_safe);
      quo_u    = a / b_safe;
      rem_u    = a % b_safe;
   end

   // Select the HI/LO pair for the latched operation.
   always_comb begin
      hi_next = '0;
      lo_next = '0;
      case (op)
         MD_MULT:  {hi_next, lo_next} = prod_s;
         MD_MULTU: {hi_next, lo_next} = prod_u;
         MD_DIV: begin
            if (div_zero) begin
               hi_next = a;
               lo_next = '1;
            end else if (div_ovf) begin
               hi_next = '0;
               lo_next = a;
            end else begin
               hi_next = rem_s;
               lo_next = quo_s;
            end
         end
         MD_DIVU: begin
            if (div_zero) begin
               hi_next = a;
               lo_next = '1;
            end else begin
               hi_next = rem_u;
               lo_next = quo_u;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and a
// busy interlock for the hazard logic.
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   md_arith #(
      .WIDTH(WIDTH)
   ) u_arith (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .hi_next(res_hi),
      .lo_next(res_lo)
   );

   // Next-state: issue in IDLE, count down in RUN, commit HI/LO as the count hits 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  MD_MULT, MD_MULTU: begin
                     a_d     = a;
                     b_d     = b;
                     op_d    = op;
                     cnt_d   = CNT_W'(MULT_LAT);
                     state_d = RUN;
                  end
                  MD_DIV, MD_DIVU: begin
                     a_d     = a;
                     b_d     = b;
                     op_d    = op;
                     cnt_d   = CNT_W'(DIV_LAT);
                     state_d = RUN;
                  end
                  MD_MTHI: hi_d = a;
                  MD_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = res_hi;
               lo_d    = res_lo;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   md_unit #(
      .WIDTH   (32),
      .MULT_LAT(5),
      .DIV_LAT (10)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .busy (busy),
      .done (done),
      .hi   (hi),
      .lo   (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one start strobe; returns at the negedge after the sampling edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count busy cycles and done pulses (bounded), and whether HI/LO held while busy.
   task automatic wait_op(output int bcnt, output int dcnt, output bit held);
      logic [31:0] h0, l0;
      h0   = hi;
      l0   = lo;
      bcnt = 0;
      dcnt = 0;
      held = 1'b1;
      while (busy === 1'b1 && bcnt < 40) begin
         bcnt++;
         if (done === 1'b1) dcnt++;
         if (hi !== h0 || lo !== l0) held = 1'b0;
         @(negedge clk);
      end
      if (done === 1'b1) dcnt++;
      @(negedge clk);
      if (done === 1'b1) dcnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      op    = 3'd7;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
      checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
   endtask

   task automatic test_mult();
      int bc, dc; bit held;
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      wait_op(bc, dc, held);
      checks++; if (bc !== 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", bc); end
      checks++; if (dc !== 1) begin failures++; $display("FAIL mult_done_pulses got=%0d exp=1", dc); end
      checks++; if (held !== 1'b1) begin failures++; $display("FAIL mult_hilo_held got=%b exp=1", held); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
   endtask

   task automatic test_multu();
      int bc, dc; bit held;
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_op(bc, dc, held);
      checks++; if (bc !== 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", bc); end
      checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
      checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
   endtask

   task automatic test_div();
      int bc, dc; bit held;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_op(bc, dc, held);
      checks++; if (bc !== 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", bc); end
      checks++; if (dc !== 1) begin failures++; $display("FAIL div_done_pulses got=%0d exp=1", dc); end
      checks++; if (held !== 1'b1) begin failures++; $display("FAIL div_hilo_held got=%b exp=1", held); end
      checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
   endtask

   task automatic test_div_special();
      int bc, dc; bit held;
      issue(3'd3, 32'd7, 32'd0);
      wait_op(bc, dc, held);
      checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_zero_lo got=%h exp=ffffffff", lo); end
      checks++; if (hi !== 32'h0000_0007) begin failures++; $display("FAIL divu_zero_hi got=%h exp=00000007", hi); end
      issue(3'd2, 32'hFFFF_FFF9, 32'd0);
      wait_op(bc, dc, held);
      checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_zero_lo got=%h exp=ffffffff", lo); end
      checks++; if (hi !== 32'hFFFF_FFF9) begin failures++; $display("FAIL div_zero_hi got=%h exp=fffffff9", hi); end
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_op(bc, dc, held);
      checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
      checks++; if (hi !== 32'h0000_0000) begin failures++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_op(bc, dc, held);
      checks++; if (lo !== 32'h0000_0000) begin failures++; $display("FAIL divu_big_lo got=%h exp=00000000", lo); end
      checks++; if (hi !== 32'h8000_0000) begin failures++; $display("FAIL divu_big_hi got=%h exp=80000000", hi); end
   endtask

   task automatic test_mthi();
      logic [31:0] lo_before;
      lo_before = lo;
      issue(3'd4, 32'h0000_1234, 32'hDEAD_BEEF);
      checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi_hi got=%h exp=00001234", hi); end
      checks++; if (lo !== lo_before) begin failures++; $display("FAIL mthi_lo got=%h exp=%h", lo, lo_before); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mthi_done got=%b exp=0", done); end
      issue(3'd6, 32'h5555_5555, 32'h0);
      checks++; if (hi !== 32'h0000_1234 || busy !== 1'b0) begin failures++; $display("FAIL nop_op6 got hi=%h busy=%b exp hi=00001234 busy=0", hi, busy); end
   endtask

   task automatic test_mtlo_during_run();
      int bc, dc; bit held;
      issue(3'd0, 32'd3, 32'd4);
      start = 1'b1;
      op    = 3'd5;
      a     = 32'd5;
      b     = 32'd9;
      @(negedge clk);
      start = 1'b0;
      wait_op(bc, dc, held);
      checks++; if (bc !== 4) begin failures++; $display("FAIL mtlo_run_busy_rest got=%0d exp=4", bc); end
      checks++; if (held !== 1'b1) begin failures++; $display("FAIL mtlo_run_held got=%b exp=1", held); end
      checks++; if (lo !== 32'd12) begin failures++; $display("FAIL mtlo_run_lo got=%h exp=0000000c", lo); end
      checks++; if (hi !== 32'd0) begin failures++; $display("FAIL mtlo_run_hi got=%h exp=00000000", hi); end
   endtask

   task automatic test_back_to_back();
      int bc, dc, n; bit held;
      issue(3'd0, 32'd2, 32'd3);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done_seen got=%b exp=1", done); end
      start = 1'b1;
      op    = 3'd3;
      a     = 32'd100;
      b     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
      checks++; if (lo !== 32'd6) begin failures++; $display("FAIL b2b_first_lo got=%h exp=00000006", lo); end
      wait_op(bc, dc, held);
      checks++; if (bc !== 10) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=10", bc); end
      checks++; if (lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("FAIL b2b_divu got hi=%h lo=%h exp hi=00000002 lo=0000000e", hi, lo); end
   endtask

   task automatic test_async_reset();
      int bc, dc, dseen; bit held;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL areset_hilo got hi=%h lo=%h exp 0/0", hi, lo); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dseen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) dseen++;
      end
      checks++; if (dseen !== 0) begin failures++; $display("FAIL areset_no_done got=%0d exp=0", dseen); end
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      wait_op(bc, dc, held);
      checks++; if (bc !== 5 || dc !== 1) begin failures++; $display("FAIL areset_fresh_mult got busy=%0d done=%0d exp 5/1", bc, dc); end
      checks++; if (lo !== 32'hFFFF_FFFA || hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL areset_fresh_result got hi=%h lo=%h exp ffffffff/fffffffa", hi, lo); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_special();
      test_mthi();
      test_mtlo_during_run();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
